// File: rtl/status_indicator.sv
// Multi-channel LED/buzzer driver: off, on, slow/fast blink or N-pulse burst per channel.
// Latency: mode/state to power is 1 cycle (registered); free-running, no backpressure.
module status_indicator #(
    parameter int CHANNELS  = 4,
    parameter int CLK_HZ    = 27000000,
    parameter int TICK_HZ   = 8,
    parameter int CNT_W     = 4,
    parameter int GAP_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sync,
    input  logic [3*CHANNELS-1:0]     mode,
    input  logic [CNT_W*CHANNELS-1:0] count,
    output logic                      tick,
    output logic [CHANNELS-1:0]       power
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

    typedef enum logic [1:0] {
        ST_START,
        ST_ON,
        ST_OFF,
        ST_GAP
    } burst_e;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick_q, tick_d;
    logic [2:0]          phase_q, phase_d;
    logic [CHANNELS-1:0] power_q, power_d;

    burst_e              st_q  [CHANNELS];
    burst_e              st_d  [CHANNELS];
    logic [CNT_W-1:0]    rem_q [CHANNELS];
    logic [CNT_W-1:0]    rem_d [CHANNELS];
    logic [GAP_W-1:0]    gap_q [CHANNELS];
    logic [GAP_W-1:0]    gap_d [CHANNELS];

    // Shared prescaler and blink phase keep all blinking channels in lock-step.
    always_comb begin
        pre_d   = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        tick_d  = (pre_q == PRE_MAX);
        phase_d = tick_q ? phase_q + 3'd1 : phase_q;
        if (sync) begin
            pre_d   = '0;
            tick_d  = 1'b0;
            phase_d = '0;
        end
    end

    always_comb begin
        st_d    = st_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        power_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick_q) begin
                case (st_q[i])
                    ST_ON: begin
                        st_d[i]  = ST_OFF;
                        rem_d[i] = rem_q[i] - 1'b1;
                    end
                    ST_OFF: begin
                        if (rem_q[i] == '0) begin
                            st_d[i]  = ST_GAP;
                            gap_d[i] = GAP_LOAD;
                        end else begin
                            st_d[i] = ST_ON;
                        end
                    end
                    ST_GAP: begin
                        gap_d[i] = gap_q[i] - 1'b1;
                        if (gap_q[i] == GAP_LAST) begin
                            if (count[CNT_W*i +: CNT_W] == '0) begin
                                st_d[i]  = ST_GAP;
                                gap_d[i] = GAP_LOAD;
                            end else begin
                                st_d[i]  = ST_ON;
                                rem_d[i] = count[CNT_W*i +: CNT_W];
                            end
                        end
                    end
                    default: begin
                        // START: count is only sampled here and on gap reload.
                        if (count[CNT_W*i +: CNT_W] == '0) begin
                            st_d[i]  = ST_GAP;
                            gap_d[i] = GAP_LOAD;
                        end else begin
                            st_d[i]  = ST_ON;
                            rem_d[i] = count[CNT_W*i +: CNT_W];
                        end
                    end
                endcase
            end
            if (sync || (mode[3*i +: 3] != 3'd4)) begin
                st_d[i] = ST_START;
            end

            case (mode[3*i +: 3])
                3'd1:    power_d[i] = 1'b1;
                3'd2:    power_d[i] = phase_q[2];
                3'd3:    power_d[i] = phase_q[0];
                3'd4:    power_d[i] = (st_q[i] == ST_ON);
                default: power_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            phase_q <= '0;
            power_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= ST_START;
                rem_q[i] <= '0;
                gap_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            power_q <= power_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                rem_q[i] <= rem_d[i];
                gap_q[i] <= gap_d[i];
            end
        end
    end

    assign tick  = tick_q;
    assign power = power_q;

endmodule

// File: tb/tb_status_indicator.sv
// Scoreboard bench for status_indicator at DIV=10: expectations keyed by cycle, checked by a monitor.
module tb_status_indicator;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync;
    logic [11:0] mode;
    logic [15:0] count;
    logic        tick;
    logic [3:0]  power;

    status_indicator #(
        .CHANNELS (4),
        .CLK_HZ   (40),
        .TICK_HZ  (4),
        .CNT_W    (4),
        .GAP_TICKS(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sync (sync),
        .mode (mode),
        .count(count),
        .tick (tick),
        .power(power)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         is_tick;
        logic [3:0] mask;
        logic [3:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the DUT presents tick/power; compare any expectation due now.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                n_chk++;
                if (sb[k].is_tick) begin
                    if (tick !== sb[k].exp[0]) begin
                        n_fail++;
                        $display("FAIL %s @cyc %0d: tick=%b, expected %b", sb[k].name, cyc, tick, sb[k].exp[0]);
                    end
                end else if ((power & sb[k].mask) !== (sb[k].exp & sb[k].mask)) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: power=%b, expected %b (mask %b)",
                             sb[k].name, cyc, power, sb[k].exp, sb[k].mask);
                end
                sb.delete(k);
            end
        end
        if (done) begin
            for (int k = 0; k < sb.size(); k++) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s: never evaluated (due cyc %0d, now %0d)", sb[k].name, sb[k].cyc, cyc);
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not reach end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic chk_pw(input int c, input logic [3:0] m, input logic [3:0] e, input string n);
        chk_t t;
        t.cyc = c; t.is_tick = 1'b0; t.mask = m; t.exp = e; t.name = n;
        sb.push_back(t);
    endtask

    task automatic chk_tk(input int c, input bit e, input string n);
        chk_t t;
        t.cyc = c; t.is_tick = 1'b1; t.mask = 4'b0000; t.exp = {3'b000, e}; t.name = n;
        sb.push_back(t);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input int ch, input logic [2:0] m);
        mode[3*ch +: 3] = m;
    endtask

    task automatic set_count(input int ch, input logic [3:0] c);
        count[4*ch +: 4] = c;
    endtask

    // ch3 burst expectations: tick interval j (power window R+10j+2..R+10j+11), level.
    int bj[26] = '{ 9, 10, 11, 12, 13, 14, 15, 18, 19, 20, 21, 24, 25,
                   26, 28, 30, 31, 33, 35, 36, 37, 38, 39, 40, 43, 44};
    bit bv[26] = '{ 1,  0,  1,  0,  1,  0,  0,  0,  1,  0,  0,  0,  1,
                    0,  0,  0,  0,  0,  0,  1,  0,  1,  0,  0,  0,  1};

    int r;
    int y;
    int z;

    initial begin
        reset = 1'b1;
        sync  = 1'b0;
        mode  = '0;
        count = '0;
        repeat (3) @(posedge clk);
        #1;
        r = cyc;
        y = r + 455;
        z = r + 555;
        reset = 1'b0;

        chk_pw(r,      4'hF, 4'b0000, "reset_power");
        chk_tk(r,      1'b0, "reset_tick");
        chk_tk(r + 9,  1'b0, "tick_not_early");
        chk_tk(r + 10, 1'b1, "first_tick");
        chk_tk(r + 11, 1'b0, "tick_width");
        chk_tk(r + 19, 1'b0, "tick2_not_early");
        chk_tk(r + 20, 1'b1, "second_tick");
        chk_tk(r + 30, 1'b1, "third_tick");

        chk_pw(r + 3,  4'hF, 4'b0000, "mode_not_yet");
        chk_pw(r + 4,  4'hF, 4'b0001, "on_latency");
        chk_pw(r + 11, 4'hF, 4'b0001, "phase0_end");
        chk_pw(r + 12, 4'hF, 4'b0101, "phase1_start");
        chk_pw(r + 21, 4'hF, 4'b0101, "phase1_end");
        chk_pw(r + 22, 4'hF, 4'b0001, "phase2_start");
        chk_pw(r + 41, 4'hF, 4'b0101, "phase3_end");
        chk_pw(r + 42, 4'hF, 4'b0011, "slow_rise");
        chk_pw(r + 52, 4'hF, 4'b0111, "phase5");
        chk_pw(r + 81, 4'hF, 4'b0111, "phase7_end");
        chk_pw(r + 82, 4'hF, 4'b0001, "phase_wrap");

        chk_pw(r + 91, 4'b1000, 4'b0000, "burst_before_tick");
        chk_pw(r + 92, 4'b1000, 4'b1000, "burst_first_pulse");
        for (int k = 0; k < 26; k++)
            chk_pw(r + 10 * bj[k] + 5, 4'b1000, {bv[k], 3'b000}, $sformatf("burst_j%0d", bj[k]));
        chk_pw(r + 361, 4'b1000, 4'b0000, "restart_before_tick");
        chk_pw(r + 362, 4'b1000, 4'b1000, "restart_first_pulse");

        chk_pw(y + 1,  4'b0111, 4'b0111, "sync_power_kept");
        chk_pw(y + 2,  4'hF,    4'b0001, "sync_phase0");
        chk_tk(y + 5,  1'b0, "sync_old_tick_gone");
        chk_tk(y + 10, 1'b0, "sync_tick_not_early");
        chk_tk(y + 11, 1'b1, "sync_first_tick");
        chk_tk(y + 12, 1'b0, "sync_tick_width");
        chk_pw(y + 12, 4'b1000, 4'b0000, "sync_burst_start");
        chk_pw(y + 13, 4'b1000, 4'b1000, "sync_burst_pulse");
        chk_pw(y + 42, 4'b0010, 4'b0000, "sync_slow_low");
        chk_pw(y + 43, 4'b0010, 4'b0010, "sync_slow_rise");

        chk_pw(z + 1,  4'hF,    4'b0000, "rst_sync_power_clear");
        chk_pw(z + 2,  4'hF,    4'b0001, "rst_sync_phase0");
        chk_tk(z + 10, 1'b0, "rst_sync_tick_not_early");
        chk_tk(z + 11, 1'b1, "rst_sync_first_tick");
        chk_pw(z + 13, 4'b1000, 4'b1000, "rst_sync_burst_pulse");
        chk_pw(z + 42, 4'b0010, 4'b0000, "rst_sync_slow_low");
        chk_pw(z + 43, 4'b0010, 4'b0010, "rst_sync_slow_rise");

        goto(r + 3);
        set_mode(0, 3'd1);
        set_mode(1, 3'd2);
        set_mode(2, 3'd3);

        goto(r + 83);
        set_count(3, 4'd3);
        set_mode(3, 3'd4);

        goto(r + 125);
        set_count(3, 4'd1);

        goto(r + 273);
        set_count(3, 4'd0);

        goto(r + 353);
        set_mode(3, 3'd0);

        goto(r + 356);
        set_count(3, 4'd2);
        set_mode(3, 3'd4);

        goto(y);
        sync = 1'b1;
        goto(y + 1);
        sync = 1'b0;

        goto(z);
        reset = 1'b1;
        sync  = 1'b1;
        goto(z + 1);
        reset = 1'b0;
        sync  = 1'b0;

        goto(z + 60);
        done = 1'b1;
    end

endmodule
